alu_rs: RTL and testbench
=========================

Name: alu_rs

Overview:
Reservation station and issue scheduler for the integer ALU in the out-of-order core. It accepts dispatched ALU instructions whose operands may still be pending on producer tags. It snoops the two common data buses (ALU result and load/store result) to wake up pending operands. Each cycle it issues the oldest ready entry to the ALU through a registered issue interface.

Parameters:
DEPTH, 8, number of station entries (power of two, 2..16)
DATA_W, 32, operand/result width
TAG_W, 4, producer tag width; all-ones (TAG_FREE) = "operand valid, no dependency"
NAME_W, 5, destination register name width
OP_W, 5, ALU opcode width
ADDR_W, 32, instruction address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
flush_en  in  1  misprediction/jump flush; kills all entries
disp_en  in  1  dispatch valid
disp_op  in  OP_W  opcode
disp_val_o / disp_val_t  in  DATA_W  operand O/T value (meaningful when the matching tag is TAG_FREE)
disp_tag_o / disp_tag_t  in  TAG_W  operand O/T producer tag
disp_wrt_tag  in  TAG_W  result tag
disp_wrt_name  in  NAME_W  destination register name
disp_addr  in  ADDR_W  instruction address
rs_full  out  1  no free entry
cdb_alu_en, cdb_alu_tag, cdb_alu_data  in  1/TAG_W/DATA_W  ALU broadcast
cdb_ls_en, cdb_ls_tag, cdb_ls_data  in  1/TAG_W/DATA_W  load/store broadcast
alu_work_en  out  1  issue valid
alu_operand_o, alu_operand_t  out  DATA_W  issued operands
alu_wrt_tag  out  TAG_W  issued result tag
alu_wrt_name  out  NAME_W  issued destination register name
alu_op  out  OP_W  issued opcode
alu_inst_addr  out  ADDR_W  issued instruction address

Behaviour:
- Reset (clk edge with rst=1):
  - All entries invalid; age matrix cleared.
  - alu_work_en=0; alu_wrt_tag=TAG_FREE; all other issue outputs 0.
  - rs_full=0.
  - rst has priority over all other inputs.
- Entry contents: valid, op, val_o/tag_o, val_t/tag_t, wrt_tag, wrt_name, addr.
  - An operand is ready when its tag == TAG_FREE.
  - An entry is ready when valid and both operands are ready.
- Dispatch: on an edge with disp_en=1, rs_full=0, flush_en=0, the lowest-index free entry is written.
  - Dispatch-time capture: if a dispatched operand tag matches an active CDB tag in the same cycle, store that CDB data and set the tag to TAG_FREE.
  - disp_en while rs_full=1 is dropped silently; upstream must stall.
- Wake-up: each edge, for every valid entry, an operand whose tag equals cdb_alu_tag (when cdb_alu_en) or cdb_ls_tag (when cdb_ls_en) latches that data and its tag becomes TAG_FREE.
  - If both buses match the same tag, ALU data wins.
  - TAG_FREE on a CDB never matches.
- Age: DEPTH x DEPTH age matrix. On dispatch, the new entry is marked younger than all currently valid entries.
- Select: combinational, among ready entries registered before this edge; pick the oldest.
  - At most one issue per cycle.
  - The issued entry is invalidated on the same edge that loads the issue registers.
- Issue registers: on each edge, if a ready entry exists, load its fields and set alu_work_en=1; otherwise alu_work_en=0, alu_wrt_tag=TAG_FREE, other outputs hold.
  - There is no ALU back-pressure; the ALU accepts one op per cycle.
- Latency: a dispatch with both operands ready, into an empty station, gives alu_work_en=1 in the cycle after the second edge (the dispatch edge plus the issue edge).
- A woken entry is eligible on the cycle after the wake-up edge.
- rs_full: registered. Next value = (valid count after this edge's dispatch/issue/flush) == DEPTH.
  - Dispatch and issue on the same edge at DEPTH-1 valid: count unchanged.
- Flush: edge with flush_en=1 clears all valid bits, the age matrix, and alu_work_en.
  - Dispatch and CDB inputs are ignored on that edge.
  - rs_full=0 next cycle.
- Wrap/reuse: freed entries are reusable on the next edge; age comes only from the matrix, never from index order.

Optional Feature:
ALU_RS_BYPASS_EN: enables same-cycle wake-up-and-issue.
- Defined: select also treats an operand as ready when its tag matches an active CDB tag this cycle. The issue register takes the CDB data for that operand, saving one cycle. Oldest-first rule unchanged. Dispatch itself still needs one edge before issue.
- Undefined: wake-up must be registered before selection, exactly as in Behaviour.

Test Plan:
- Reset then dispatch {op=ADD, O=5/TAG_FREE, T=7/TAG_FREE, wrt_tag=3} -> alu_work_en=1 two edges later with operands 5,7 and alu_wrt_tag=3; then 0.
- Dispatch A (tag_o=2 pending), then B (ready) -> B issues first; cdb_alu {tag=2, data=0x10} -> A issues one cycle after wake-up (same cycle after CDB with ALU_RS_BYPASS_EN) with operand_o=0x10.
- Fill 8 entries, all pending on tag 5 -> rs_full=1, 9th dispatch dropped. cdb_ls tag=5 -> entries issue one per cycle in dispatch order, rs_full drops after the first issue.
- cdb_alu and cdb_ls both broadcast tag=4 with data 0xA/0xB -> woken operand=0xA.
- Dispatch operand tag=6 in the same cycle as cdb_alu tag=6, data=0x55 -> entry stored ready, issues with 0x55.
- 3 entries valid, flush_en=1 with simultaneous disp_en -> next cycle no valid entries, alu_work_en=0, rs_full=0, dispatched op absent; later rst mid-operation -> same cleared state.

Source files
------------

// File: rtl/alu_rs_if.sv
// alu_rs_if: dispatch, common data bus and issue signals of the ALU reservation station
interface alu_rs_if #(
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int NAME_W = 5,
  parameter int OP_W   = 5,
  parameter int ADDR_W = 32
);
  logic              flush_en;
  logic              disp_en;
  logic [OP_W-1:0]   disp_op;
  logic [DATA_W-1:0] disp_val_o;
  logic [DATA_W-1:0] disp_val_t;
  logic [TAG_W-1:0]  disp_tag_o;
  logic [TAG_W-1:0]  disp_tag_t;
  logic [TAG_W-1:0]  disp_wrt_tag;
  logic [NAME_W-1:0] disp_wrt_name;
  logic [ADDR_W-1:0] disp_addr;
  logic              rs_full;
  logic              cdb_alu_en;
  logic [TAG_W-1:0]  cdb_alu_tag;
  logic [DATA_W-1:0] cdb_alu_data;
  logic              cdb_ls_en;
  logic [TAG_W-1:0]  cdb_ls_tag;
  logic [DATA_W-1:0] cdb_ls_data;
  logic              alu_work_en;
  logic [DATA_W-1:0] alu_operand_o;
  logic [DATA_W-1:0] alu_operand_t;
  logic [TAG_W-1:0]  alu_wrt_tag;
  logic [NAME_W-1:0] alu_wrt_name;
  logic [OP_W-1:0]   alu_op;
  logic [ADDR_W-1:0] alu_inst_addr;
  modport slave (
    input  flush_en, disp_en, disp_op, disp_val_o, disp_val_t, disp_tag_o, disp_tag_t,
           disp_wrt_tag, disp_wrt_name, disp_addr,
           cdb_alu_en, cdb_alu_tag, cdb_alu_data, cdb_ls_en, cdb_ls_tag, cdb_ls_data,
    output rs_full, alu_work_en, alu_operand_o, alu_operand_t, alu_wrt_tag, alu_wrt_name,
           alu_op, alu_inst_addr
  );
  modport master (
    output flush_en, disp_en, disp_op, disp_val_o, disp_val_t, disp_tag_o, disp_tag_t,
           disp_wrt_tag, disp_wrt_name, disp_addr,
           cdb_alu_en, cdb_alu_tag, cdb_alu_data, cdb_ls_en, cdb_ls_tag, cdb_ls_data,
    input  rs_full, alu_work_en, alu_operand_o, alu_operand_t, alu_wrt_tag, alu_wrt_name,
           alu_op, alu_inst_addr
  );
endinterface

// File: rtl/alu_rs.sv
// alu_rs: ALU reservation station, oldest-ready-first issue; define ALU_RS_BYPASS_EN for same-cycle CDB wake-and-issue
module alu_rs #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  parameter int TAG_W  = 4,
  parameter int NAME_W = 5,
  parameter int OP_W   = 5,
  parameter int ADDR_W = 32
) (
  input logic   clk,
  input logic   rst,
  alu_rs_if.slave io
);
  localparam int IW = $clog2(DEPTH);
  localparam logic [TAG_W-1:0] FREE = '1;
`ifdef ALU_RS_BYPASS_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif
  logic [DEPTH-1:0]  vld, rdy, vn;
  logic [DEPTH-1:0]  old [DEPTH];
  logic [OP_W-1:0]   op [DEPTH];
  logic [DATA_W-1:0] vo [DEPTH], vt [DEPTH], bo [DEPTH], bt [DEPTH];
  logic [TAG_W-1:0]  to [DEPTH], tt [DEPTH], wo [DEPTH], wtt [DEPTH], rt [DEPTH];
  logic [NAME_W-1:0] rn [DEPTH];
  logic [ADDR_W-1:0] ad [DEPTH];
  logic [TAG_W-1:0]  dto, dtt;
  logic [DATA_W-1:0] dvo, dvt;
  logic [IW-1:0]     fi, si;
  logic              hf, hs, de, ae, le;
  int                cnt;
  assign ae = io.cdb_alu_en && io.cdb_alu_tag != FREE;
  assign le = io.cdb_ls_en && io.cdb_ls_tag != FREE;
  function automatic logic [TAG_W+DATA_W-1:0] wake(input logic [TAG_W-1:0] t, input logic [DATA_W-1:0] v);
    return (ae && io.cdb_alu_tag == t) ? {FREE, io.cdb_alu_data} :
           (le && io.cdb_ls_tag == t) ? {FREE, io.cdb_ls_data} : {t, v};
  endfunction
  // snoop buses, find free slot, pick the oldest ready entry, compute next occupancy
  always_comb begin
    {dto, dvo} = wake(io.disp_tag_o, io.disp_val_o);
    {dtt, dvt} = wake(io.disp_tag_t, io.disp_val_t);
    fi = '0;
    hf = 1'b0;
    si = '0;
    hs = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      {wo[i], bo[i]} = wake(to[i], vo[i]);
      {wtt[i], bt[i]} = wake(tt[i], vt[i]);
      rdy[i] = vld[i] && (BP ? wo[i] : to[i]) == FREE && (BP ? wtt[i] : tt[i]) == FREE;
      if (!vld[i]) begin
        fi = IW'(i);
        hf = 1'b1;
      end
    end
    for (int i = 0; i < DEPTH; i++)
      if (rdy[i] && !(|(rdy & old[i]))) begin
        si = IW'(i);
        hs = 1'b1;
      end
    de = io.disp_en && !io.rs_full && !io.flush_en && hf;
    vn = vld;
    if (hs) vn[si] = 1'b0;
    if (de) vn[fi] = 1'b1;
    cnt = 0;
    for (int i = 0; i < DEPTH; i++) cnt += int'(vn[i]);
  end
  // entry storage: wake-up, dispatch write and age-matrix update
  always_ff @(posedge clk) begin
    if (rst || io.flush_en) begin
      vld <= '0;
      for (int i = 0; i < DEPTH; i++) old[i] <= '0;
    end else begin
      vld <= vn;
      for (int i = 0; i < DEPTH; i++) begin
        to[i] <= wo[i];
        vo[i] <= bo[i];
        tt[i] <= wtt[i];
        vt[i] <= bt[i];
        if (de) old[i][fi] <= 1'b0;
      end
      if (de) begin
        op[fi]  <= io.disp_op;
        to[fi]  <= dto;
        vo[fi]  <= dvo;
        tt[fi]  <= dtt;
        vt[fi]  <= dvt;
        rt[fi]  <= io.disp_wrt_tag;
        rn[fi]  <= io.disp_wrt_name;
        ad[fi]  <= io.disp_addr;
        old[fi] <= vld;
      end
    end
  end
  // issue registers toward the ALU
  always_ff @(posedge clk) begin
    if (rst) begin
      io.alu_work_en   <= 1'b0;
      io.alu_operand_o <= '0;
      io.alu_operand_t <= '0;
      io.alu_wrt_tag   <= FREE;
      io.alu_wrt_name  <= '0;
      io.alu_op        <= '0;
      io.alu_inst_addr <= '0;
    end else if (hs && !io.flush_en) begin
      io.alu_work_en   <= 1'b1;
      io.alu_operand_o <= bo[si];
      io.alu_operand_t <= bt[si];
      io.alu_wrt_tag   <= rt[si];
      io.alu_wrt_name  <= rn[si];
      io.alu_op        <= op[si];
      io.alu_inst_addr <= ad[si];
    end else begin
      io.alu_work_en <= 1'b0;
      io.alu_wrt_tag <= FREE;
    end
  end
  // registered full flag from post-edge occupancy
  always_ff @(posedge clk) io.rs_full <= (rst || io.flush_en) ? 1'b0 : cnt == DEPTH;
endmodule

// File: tb/tb_alu_rs.sv
// tb_alu_rs: randomized and directed checks of alu_rs against an in-order queue model
module tb_alu_rs;
  localparam int DEPTH = 8, DW = 32, TW = 4, NW = 5, OW = 5, AW = 32;
  localparam int VW = 1 + DW + DW + TW + NW + OW + AW + 1;
  localparam logic [TW-1:0] F = '1;
`ifdef ALU_RS_BYPASS_EN
  localparam bit BP = 1'b1;
`else
  localparam bit BP = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst = 1'b1;
  alu_rs_if #(.DATA_W(DW), .TAG_W(TW), .NAME_W(NW), .OP_W(OW), .ADDR_W(AW)) io ();
  alu_rs #(.DEPTH(DEPTH), .DATA_W(DW), .TAG_W(TW), .NAME_W(NW), .OP_W(OW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .io(io)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [OW-1:0] op;
    logic [DW-1:0] vo, vt;
    logic [TW-1:0] to, tt, wt;
    logic [NW-1:0] wn;
    logic [AW-1:0] ad;
  } ent_t;
  ent_t q[$];
  logic m_en, m_full;
  logic [DW-1:0] m_o, m_t;
  logic [TW-1:0] m_tag;
  logic [NW-1:0] m_name;
  logic [OW-1:0] m_op;
  logic [AW-1:0] m_addr;
  int checks = 0, errors = 0;
  logic [VW-1:0] rstv;
  function automatic logic ha(input logic [TW-1:0] t);
    return io.cdb_alu_en && io.cdb_alu_tag != F && io.cdb_alu_tag == t;
  endfunction
  function automatic logic hl(input logic [TW-1:0] t);
    return io.cdb_ls_en && io.cdb_ls_tag != F && io.cdb_ls_tag == t;
  endfunction
  function automatic logic [DW-1:0] wv(input logic [TW-1:0] t, input logic [DW-1:0] v);
    return ha(t) ? io.cdb_alu_data : hl(t) ? io.cdb_ls_data : v;
  endfunction
  function automatic logic [TW-1:0] wtag(input logic [TW-1:0] t);
    return (ha(t) || hl(t)) ? F : t;
  endfunction
  function automatic logic rd(input logic [TW-1:0] t);
    return t == F || (BP && (ha(t) || hl(t)));
  endfunction
  function automatic logic [VW-1:0] obs();
    return {io.alu_work_en, io.alu_operand_o, io.alu_operand_t, io.alu_wrt_tag,
            io.alu_wrt_name, io.alu_op, io.alu_inst_addr, io.rs_full};
  endfunction
  function automatic logic [VW-1:0] exp_v();
    return {m_en, m_o, m_t, m_tag, m_name, m_op, m_addr, m_full};
  endfunction
  task automatic model_step();
    ent_t e;
    int s;
    if (rst) begin
      q.delete();
      {m_en, m_o, m_t, m_name, m_op, m_addr, m_full} = '0;
      m_tag = F;
    end else if (io.flush_en) begin
      q.delete();
      m_en = 1'b0;
      m_tag = F;
      m_full = 1'b0;
    end else begin
      s = -1;
      foreach (q[i]) if (s < 0 && rd(q[i].to) && rd(q[i].tt)) s = i;
      if (s >= 0) begin
        e = q[s];
        m_en = 1'b1;
        m_o = wv(e.to, e.vo);
        m_t = wv(e.tt, e.vt);
        m_tag = e.wt;
        m_name = e.wn;
        m_op = e.op;
        m_addr = e.ad;
        q.delete(s);
      end else begin
        m_en = 1'b0;
        m_tag = F;
      end
      foreach (q[i]) begin
        q[i].vo = wv(q[i].to, q[i].vo);
        q[i].to = wtag(q[i].to);
        q[i].vt = wv(q[i].tt, q[i].vt);
        q[i].tt = wtag(q[i].tt);
      end
      if (io.disp_en && !m_full) begin
        e.op = io.disp_op;
        e.vo = wv(io.disp_tag_o, io.disp_val_o);
        e.to = wtag(io.disp_tag_o);
        e.vt = wv(io.disp_tag_t, io.disp_val_t);
        e.tt = wtag(io.disp_tag_t);
        e.wt = io.disp_wrt_tag;
        e.wn = io.disp_wrt_name;
        e.ad = io.disp_addr;
        q.push_back(e);
      end
      m_full = q.size() == DEPTH;
    end
  endtask
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic en, input logic [OW-1:0] op, input logic [DW-1:0] vo, input logic [TW-1:0] to,
                       input logic [DW-1:0] vt, input logic [TW-1:0] tt, input logic [TW-1:0] wt,
                       input logic [NW-1:0] wn, input logic [AW-1:0] ad);
    io.disp_en = en;
    io.disp_op = op;
    io.disp_val_o = vo;
    io.disp_tag_o = to;
    io.disp_val_t = vt;
    io.disp_tag_t = tt;
    io.disp_wrt_tag = wt;
    io.disp_wrt_name = wn;
    io.disp_addr = ad;
  endtask
  task automatic cdb(input logic ae, input logic [TW-1:0] at, input logic [DW-1:0] adt,
                     input logic le, input logic [TW-1:0] lt, input logic [DW-1:0] ldt);
    io.cdb_alu_en = ae;
    io.cdb_alu_tag = at;
    io.cdb_alu_data = adt;
    io.cdb_ls_en = le;
    io.cdb_ls_tag = lt;
    io.cdb_ls_data = ldt;
  endtask
  task automatic idle();
    io.flush_en = 1'b0;
    drive(1'b0, '0, '0, F, '0, F, F, '0, '0);
    cdb(1'b0, F, '0, 1'b0, F, '0);
  endtask
  task automatic test_reset();
    rst = 1'b1;
    idle();
    tick();
    tick();
    checks++;
    if (obs() !== rstv) begin
      errors++;
      $display("FAIL reset got=%h exp=%h", obs(), rstv);
    end
    rst = 1'b0;
  endtask
  task automatic test_basic();
    drive(1'b1, 5'd1, 32'd5, F, 32'd7, F, 4'd3, 5'd9, 32'h100);
    tick();
    idle();
    checks++;
    if (io.alu_work_en !== 1'b0) begin
      errors++;
      $display("FAIL basic_early got=%b exp=0", io.alu_work_en);
    end
    tick();
    checks++;
    if ({io.alu_work_en, io.alu_operand_o, io.alu_operand_t, io.alu_wrt_tag} !== {1'b1, 32'd5, 32'd7, 4'd3}) begin
      errors++;
      $display("FAIL basic_issue got=%b/%0d/%0d/%0d exp=1/5/7/3", io.alu_work_en, io.alu_operand_o,
               io.alu_operand_t, io.alu_wrt_tag);
    end
    tick();
    checks++;
    if (obs() !== exp_v() || io.alu_work_en !== 1'b0) begin
      errors++;
      $display("FAIL basic_after got=%h exp=%h", obs(), exp_v());
    end
  endtask
  task automatic test_order();
    int seen = 0;
    drive(1'b1, 5'd2, 32'd0, 4'd2, 32'd1, F, 4'd8, 5'd1, 32'hA0);
    tick();
    drive(1'b1, 5'd3, 32'd2, F, 32'd3, F, 4'd9, 5'd2, 32'hB0);
    tick();
    idle();
    tick();
    checks++;
    if (obs() !== exp_v() || io.alu_inst_addr !== 32'hB0) begin
      errors++;
      $display("FAIL order_b got=%h exp=%h", obs(), exp_v());
    end
    cdb(1'b1, 4'd2, 32'h10, 1'b0, F, '0);
    for (int k = 0; k < 3; k++) begin
      tick();
      idle();
      if (io.alu_work_en && io.alu_operand_o == 32'h10 && io.alu_inst_addr == 32'hA0) seen++;
      checks++;
      if (obs() !== exp_v()) begin
        errors++;
        $display("FAIL order_a cyc=%0d got=%h exp=%h", k, obs(), exp_v());
      end
    end
    checks++;
    if (seen != 1) begin
      errors++;
      $display("FAIL order_woken got=%0d exp=1", seen);
    end
  endtask
  task automatic test_full();
    for (int k = 0; k < DEPTH + 1; k++) begin
      drive(1'b1, OW'(k), 32'd0, 4'd5, DW'(k), F, TW'(k), NW'(k), 32'h90 + AW'(k));
      tick();
      checks++;
      if (obs() !== exp_v()) begin
        errors++;
        $display("FAIL fill cyc=%0d got=%h exp=%h", k, obs(), exp_v());
      end
    end
    checks++;
    if (io.rs_full !== 1'b1) begin
      errors++;
      $display("FAIL full_flag got=%b exp=1", io.rs_full);
    end
    idle();
    cdb(1'b0, F, '0, 1'b1, 4'd5, 32'h77);
    for (int k = 0; k < DEPTH + 3; k++) begin
      tick();
      idle();
      checks++;
      if (obs() !== exp_v()) begin
        errors++;
        $display("FAIL drain cyc=%0d got=%h exp=%h", k, obs(), exp_v());
      end
    end
  endtask
  task automatic test_both();
    drive(1'b1, 5'd4, 32'd1, F, 32'd0, 4'd4, 4'd2, 5'd3, 32'hC0);
    tick();
    idle();
    cdb(1'b1, 4'd4, 32'hA, 1'b1, 4'd4, 32'hB);
    tick();
    idle();
    tick();
    tick();
    checks++;
    if (obs() !== exp_v()) begin
      errors++;
      $display("FAIL both got=%h exp=%h", obs(), exp_v());
    end
  endtask
  task automatic test_capture();
    drive(1'b1, 5'd5, 32'd0, 4'd6, 32'd9, F, 4'd1, 5'd4, 32'hD0);
    cdb(1'b1, 4'd6, 32'h55, 1'b0, F, '0);
    tick();
    idle();
    tick();
    checks++;
    if ({io.alu_work_en, io.alu_operand_o, io.alu_inst_addr} !== {1'b1, 32'h55, 32'hD0}) begin
      errors++;
      $display("FAIL capture got=%b/%h/%h exp=1/55/d0", io.alu_work_en, io.alu_operand_o, io.alu_inst_addr);
    end
  endtask
  task automatic test_flush();
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, 5'd6, 32'd0, 4'd7, 32'd0, F, TW'(k), NW'(k), 32'hE0 + AW'(k));
      tick();
    end
    io.flush_en = 1'b1;
    drive(1'b1, 5'd7, 32'd1, F, 32'd2, F, 4'd3, 5'd5, 32'hDEAD);
    tick();
    checks++;
    if ({io.alu_work_en, io.rs_full} !== 2'b00 || obs() !== exp_v()) begin
      errors++;
      $display("FAIL flush got=%h exp=%h", obs(), exp_v());
    end
    idle();
    cdb(1'b1, 4'd7, 32'h1, 1'b0, F, '0);
    for (int k = 0; k < 4; k++) begin
      tick();
      idle();
      checks++;
      if (io.alu_work_en !== 1'b0 || obs() !== exp_v()) begin
        errors++;
        $display("FAIL flush_empty cyc=%0d got=%h exp=%h", k, obs(), exp_v());
      end
    end
    drive(1'b1, 5'd8, 32'd3, F, 32'd4, F, 4'd5, 5'd6, 32'hF0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (obs() !== rstv) begin
      errors++;
      $display("FAIL reset_mid got=%h exp=%h", obs(), rstv);
    end
    rst = 1'b0;
    idle();
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (io.alu_work_en !== 1'b0 || obs() !== exp_v()) begin
        errors++;
        $display("FAIL reset_empty cyc=%0d got=%h exp=%h", k, obs(), exp_v());
      end
    end
  endtask
  function automatic logic [TW-1:0] rtag();
    return ($urandom_range(0, 2) == 0) ? F : TW'($urandom_range(0, 5));
  endfunction
  task automatic test_random();
    for (int k = 0; k < 500; k++) begin
      io.flush_en = $urandom_range(0, 59) == 0;
      drive(1'($urandom_range(0, 1)), OW'($urandom), $urandom, rtag(), $urandom, rtag(), TW'($urandom),
            NW'($urandom), $urandom);
      cdb(1'($urandom_range(0, 1)), rtag(), $urandom, 1'($urandom_range(0, 1)), rtag(), $urandom);
      tick();
      checks++;
      if (obs() !== exp_v()) begin
        errors++;
        $display("FAIL random cyc=%0d got=%h exp=%h", k, obs(), exp_v());
      end
    end
    idle();
  endtask
  initial begin
    rstv = {1'b0, {DW{1'b0}}, {DW{1'b0}}, F, {NW{1'b0}}, {OW{1'b0}}, {AW{1'b0}}, 1'b0};
    test_reset();
    test_basic();
    test_order();
    test_full();
    test_both();
    test_capture();
    test_flush();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
